// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The requester side drives req/release_grant; the arbiter drives the grant outputs.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       release_grant;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output release_grant,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_grant,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Every grant is followed by at least one idle cycle; all outputs come straight from flops.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q,       state_d;
  logic [2:0] ptr_q,         ptr_d;
  logic [2:0] grant_idx_q,   grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic [7:0] grant_q,       grant_d;
  logic       timeout_q,     timeout_d;
  logic [7:0] hold_cnt_q,    hold_cnt_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic       owner_req;
  logic       hold_expired;
  logic       end_grant;

  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] sh);
    logic [15:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[7:0];
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Rotating by ptr turns the circular search into a plain lowest-bit search;
  // adding ptr back wraps modulo 8 in the 3-bit sum.
  assign pick_found   = |bus.req;
  assign pick_idx     = ptr_q + lowest_set(rotate_right(bus.req, ptr_q));

  assign owner_req    = bus.req[grant_idx_q];
  assign hold_expired = (hold_cnt_q == HOLD_LAST);
  assign end_grant    = bus.release_grant | ~owner_req | hold_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = BUSY;
      BUSY:    if (end_grant)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_valid_d = 1'b0;
        grant_d       = 8'h00;
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          grant_d       = 8'h01 << pick_idx;
          hold_cnt_d    = 8'h00;
        end
      end
      BUSY: begin
        if (end_grant) begin
          grant_valid_d = 1'b0;
          grant_d       = 8'h00;
          ptr_d         = grant_idx_q + 3'd1;
          // A voluntary end (release or dropped request) masks a coincident expiry.
          timeout_d     = hold_expired & ~bus.release_grant & owner_req;
        end else begin
          hold_cnt_d    = hold_cnt_q + 8'h01;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        grant_d       = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= 3'd0;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_q       <= 8'h00;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= 8'h00;
    end else begin
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule
